// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I-subset sequencer (optional JAL via MULTICYCLE_CTRL_JAL_EN)
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic        instr_retired,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
`ifdef MULTICYCLE_CTRL_JAL_EN
    , S_JAL
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state;
  state_t next_state;
  state_t decode_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       f3_alu_ok;
  logic [2:0] alu_op_r;
  logic [2:0] alu_op_i;
  logic       branch_taken;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Only these funct3 values map onto an ALU operation this core supports.
  assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  // beq takes the branch on zero, bne on nonzero.
  assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  // ALU operation from funct3; only register-register ops honour funct7[5] as sub.
  always_comb begin
    alu_op_i = ALU_ADD;
    case (funct3)
      3'b010:  alu_op_i = ALU_SLT;
      3'b110:  alu_op_i = ALU_OR;
      3'b111:  alu_op_i = ALU_AND;
      default: alu_op_i = ALU_ADD;
    endcase
    alu_op_r = alu_op_i;
    if (funct3 == 3'b000 && funct7_5) alu_op_r = ALU_SUB;
  end

  // Instruction class decode used when leaving DECODE.
  always_comb begin
    decode_next = S_TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) decode_next = S_MEMADR;
      OP_RTYPE:          if (f3_alu_ok) decode_next = S_EXECR;
      OP_ITYPE:          if (f3_alu_ok) decode_next = S_EXECI;
      OP_BRANCH:         if (funct3 == 3'b000 || funct3 == 3'b001) decode_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
      OP_JAL:            decode_next = S_JAL;
`else
      OP_JAL:            decode_next = S_TRAP;
`endif
      default:           decode_next = S_TRAP;
    endcase
  end

  // State register; reset drops any in-flight access and restarts from RST.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RST;
    else        state <= next_state;
  end

  // Per-state control outputs and next-state selection.
  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    imm_src       = 3'b000;
    result_src    = 2'b00;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_RST: next_state = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = 3'b010;
        next_state = decode_next;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = opcode[5] ? 3'b001 : 3'b000;
        next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          next_state    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_ctrl   = alu_op_r;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_ctrl   = alu_op_i;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_SUB;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
`endif
      S_TRAP: illegal = 1'b1;
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic        instr_retired, illegal;
  logic [19:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .result_src(result_src),
    .instr_retired(instr_retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                alu_src_b, alu_ctrl, imm_src, result_src, instr_retired, illegal};

  typedef struct {
    logic [31:0] in;
    bit          z;
    int          cyc;
    bit          rw;
    bit          pcw;
    logic [2:0]  alu;
    bit          ill;
    bit          st;
    logic [1:0]  rs;
  } tv_t;

  tv_t tbl[$];

  function automatic logic [19:0] cv(input bit req, input bit mw, input bit adr, input bit irw,
                                     input bit pcw, input bit rw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic [1:0] rs,
                                     input bit ret, input bit ill);
    return {req, mw, adr, irw, pcw, rw, a, b, alu, imm, rs, ret, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    adv();
    rst_n = 1'b1;
    settle();
    check("rst_outputs_zero", obs, 0);
    adv();
  endtask

  // Reference: expected behaviour per instruction from its class, as a cycle budget
  // and the values seen at key points, with mem_ready held high.
  task automatic ref_info(input logic [31:0] in, input bit z, output int cyc, output bit rw,
                          output bit pcw, output logic [2:0] alu, output bit ill,
                          output bit st, output logic [1:0] rs);
    logic [6:0] op;
    logic [2:0] f3;
    bit         alu_ok;
    op  = in[6:0];
    f3  = in[14:12];
    alu_ok = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
    cyc = 3; rw = 0; pcw = 0; alu = 3'd0; ill = 1; st = 0; rs = 2'b00;
    if (op == 7'h03 && f3 == 2) begin
      cyc = 5; rw = 1; ill = 0; rs = 2'b01;
    end else if (op == 7'h23 && f3 == 2) begin
      cyc = 4; ill = 0; st = 1;
    end else if ((op == 7'h33 || op == 7'h13) && alu_ok) begin
      cyc = 4; rw = 1; ill = 0;
      case (f3)
        3'd0:    alu = (op == 7'h33 && in[30]) ? 3'd1 : 3'd0;
        3'd2:    alu = 3'd5;
        3'd6:    alu = 3'd3;
        default: alu = 3'd2;
      endcase
    end else if (op == 7'h63 && f3 <= 1) begin
      cyc = 3; ill = 0; alu = 3'd1;
      pcw = (f3 == 0) ? z : !z;
    end
`ifdef MULTICYCLE_CTRL_JAL_EN
    else if (op == 7'h6F) begin
      cyc = 4; rw = 1; ill = 0;
    end
`endif
  endtask

  // Runs one instruction from FETCH to retirement (or trap) and compares the summary.
  task automatic run_instr(input logic [31:0] in, input bit z, input bit rnd, input int e_cyc,
                           input bit e_rw, input bit e_pcw, input logic [2:0] e_alu,
                           input bit e_ill, input bit e_st, input logic [1:0] e_rs);
    int         cyc = 0, stalls = 0, rw_cnt = 0;
    bit         done = 0, ill_seen = 0, mw_seen = 0, prev_pend = 0, prev_mw = 0;
    bit         ret_pcw = 0;
    logic [1:0] ret_rs = 2'b00;
    logic [2:0] alu_obs = 3'd0;
    instr = in;
    zero  = z;
    while (!done && cyc < 64) begin
      mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      settle();
      cyc++;
      if (prev_pend) check("mem_req_held", {mem_req, mem_write}, {1'b1, prev_mw});
      prev_pend = mem_req && !mem_ready;
      prev_mw   = mem_write;
      if (mem_req && !mem_ready) stalls++;
      if (reg_write) rw_cnt++;
      if (mem_write) mw_seen = 1;
      if (alu_src_a == 2'b10) alu_obs = alu_ctrl;
      if (illegal) begin
        ill_seen = 1;
        done = 1;
      end
      if (instr_retired) begin
        ret_pcw = pc_write;
        ret_rs  = result_src;
        done    = 1;
      end
      adv();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout instr=%08h: no retire/trap in %0d cycles", in, cyc);
    end
    check("illegal", ill_seen, e_ill);
    check("cycles", cyc, e_cyc + stalls);
    if (e_ill) begin
      do_reset();
    end else begin
      check("reg_write_count", rw_cnt, e_rw);
      check("pc_write_retire", ret_pcw, e_pcw);
      check("alu_ctrl", alu_obs, e_alu);
      check("mem_write_seen", mw_seen, e_st);
      check("result_src_retire", ret_rs, e_rs);
    end
  endtask

  task automatic add_tv(input logic [31:0] in, input bit z, input int cyc, input bit rw,
                        input bit pcw, input logic [2:0] alu, input bit ill, input bit st,
                        input logic [1:0] rs);
    tv_t t;
    t.in = in; t.z = z; t.cyc = cyc; t.rw = rw; t.pcw = pcw;
    t.alu = alu; t.ill = ill; t.st = st; t.rs = rs;
    tbl.push_back(t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] lw_exp [5];
    logic [6:0]  ops [6];
    int          r_cyc;
    bit          r_rw, r_pcw, r_ill, r_st;
    logic [2:0]  r_alu;
    logic [1:0]  r_rs;
    logic [31:0] rin;
    bit          rz;

    add_tv(32'h00012283, 0, 5, 1, 0, 3'd0, 0, 0, 2'b01);
    add_tv(32'h00512023, 0, 4, 0, 0, 3'd0, 0, 1, 2'b00);
    add_tv(32'h002081B3, 0, 4, 1, 0, 3'd0, 0, 0, 2'b00);
    add_tv(32'h402081B3, 0, 4, 1, 0, 3'd1, 0, 0, 2'b00);
    add_tv(32'h0020A1B3, 0, 4, 1, 0, 3'd5, 0, 0, 2'b00);
    add_tv(32'h0020E1B3, 0, 4, 1, 0, 3'd3, 0, 0, 2'b00);
    add_tv(32'h0020F1B3, 0, 4, 1, 0, 3'd2, 0, 0, 2'b00);
    add_tv(32'h40008093, 0, 4, 1, 0, 3'd0, 0, 0, 2'b00);
    add_tv(32'h0020A093, 0, 4, 1, 0, 3'd5, 0, 0, 2'b00);
    add_tv(32'h0020E093, 0, 4, 1, 0, 3'd3, 0, 0, 2'b00);
    add_tv(32'h0020F093, 0, 4, 1, 0, 3'd2, 0, 0, 2'b00);
    add_tv(32'h00209463, 1, 3, 0, 0, 3'd1, 0, 0, 2'b00);
    add_tv(32'h00208463, 1, 3, 0, 1, 3'd1, 0, 0, 2'b00);
    add_tv(32'h00208463, 0, 3, 0, 0, 3'd1, 0, 0, 2'b00);
    add_tv(32'h00209463, 0, 3, 0, 1, 3'd1, 0, 0, 2'b00);
`ifdef MULTICYCLE_CTRL_JAL_EN
    add_tv(32'h008000EF, 0, 4, 1, 0, 3'd0, 0, 0, 2'b00);
`else
    add_tv(32'h008000EF, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);
`endif
    add_tv(32'h0000007F, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);
    add_tv(32'h00010283, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);
    add_tv(32'h002091B3, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);
    add_tv(32'h0020C463, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);
    add_tv(32'h0020C093, 0, 3, 0, 0, 3'd0, 1, 0, 2'b00);

    lw_exp[0] = cv(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'd0, 3'b000, 2'b10, 0, 0);
    lw_exp[1] = cv(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd0, 3'b010, 2'b00, 0, 0);
    lw_exp[2] = cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 3'b000, 2'b00, 0, 0);
    lw_exp[3] = cv(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 3'b000, 2'b00, 0, 0);
    lw_exp[4] = cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 3'b000, 2'b01, 1, 0);

    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = 32'h0;
    adv();
    rst_n = 1'b1;
    settle();
    check("reset_state_zero", obs, 0);
    adv();
    settle();
    check("fetch_wait", obs, cv(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'd0, 3'b000, 2'b10, 0, 0));
    adv();

    // lw with mem_ready high: five states, one retirement pulse.
    instr = 32'h00012283; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("lw_cycle%0d", i + 1), obs, lw_exp[i]);
      adv();
    end

    // sw stalled three cycles in MEMWRITE.
    instr = 32'h00512023; mem_ready = 1'b1;
    adv(); adv();
    settle();
    check("sw_memadr_imm", imm_src, 3'b001);
    adv();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("sw_stall%0d", i), {mem_req, mem_write, adr_src, instr_retired}, 4'b1110);
      adv();
    end
    mem_ready = 1'b1;
    settle();
    check("sw_ready", {mem_req, mem_write, adr_src, instr_retired}, 4'b1111);
    adv();
    mem_ready = 1'b0;
    settle();
    check("sw_then_fetch", obs, cv(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'd0, 3'b000, 2'b10, 0, 0));
    adv();

    // Illegal opcode held in TRAP until reset.
    instr = 32'h0000007F; mem_ready = 1'b1;
    adv(); adv();
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("trap_hold%0d", i), obs, 20'd1);
      adv();
    end
    do_reset();
    settle();
    check("trap_reset_fetch", {mem_req, adr_src}, 2'b10);
    adv();

    // Reset during a MEMREAD stall.
    instr = 32'h00012283; mem_ready = 1'b1;
    adv(); adv(); adv();
    mem_ready = 1'b0;
    settle();
    check("memread_stall", {mem_req, adr_src}, 2'b11);
    adv(); adv();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    settle();
    check("stall_reset_zero", obs, 0);
    adv();
    settle();
    check("stall_reset_fetch", {mem_req, adr_src, mem_write}, 3'b100);
    adv();

    foreach (tbl[i])
      run_instr(tbl[i].in, tbl[i].z, 1'b0, tbl[i].cyc, tbl[i].rw, tbl[i].pcw,
                tbl[i].alu, tbl[i].ill, tbl[i].st, tbl[i].rs);

    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6F;
    for (int n = 0; n < 150; n++) begin
      rin = $urandom;
      if ($urandom_range(0, 9) != 0) rin[6:0] = ops[$urandom_range(0, 5)];
      rz = $urandom_range(0, 1);
      ref_info(rin, rz, r_cyc, r_rw, r_pcw, r_alu, r_ill, r_st, r_rs);
      run_instr(rin, rz, 1'b1, r_cyc, r_rw, r_pcw, r_alu, r_ill, r_st, r_rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
